ws2812_tx: RTL and testbench

Serial transmitter for the WS2812 LED strip. It consumes the parallel GRB frame produced by the game pattern generator: 24 bits per LED, LED0 in the most-significant slice. It drives the strip's single-wire NRZ data line with the required high/low bit timing, then holds the line low for the latch/reset gap. It sits between the pattern logic and the strip's DIN pin.

---
 rtl/ws2812_pkg.sv | 28 ++
 rtl/ws2812_bit_timer.sv | 41 ++++
 rtl/ws2812_tx.sv | 128 ++++++++++++
 tb/tb_ws2812_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: bit timing, LED word layout and the GRB colour palette
// used by both the pattern generator and the serial transmitter.
package ws2812_pkg;

   localparam int LED_BITS = 24;

   // Bit timing in clk cycles for the 100 MHz build
   localparam int WS_T0H  = 35;
   localparam int WS_T1H  = 70;
   localparam int WS_TBIT = 125;
   localparam int WS_TRES = 30000;

   typedef logic [LED_BITS-1:0] grb_t;

   // Colours are packed G[23:16], R[15:8], B[7:0]
   localparam grb_t OFF    = 24'h000000;
   localparam grb_t RED    = 24'h00FF00;
   localparam grb_t ORANGE = 24'h80FF00;
   localparam grb_t GREEN  = 24'hFF0000;
   localparam grb_t CYAN   = 24'hFF00FF;
   localparam grb_t BLUE   = 24'h0000FF;
   localparam grb_t VIOLET = 24'h0080FF;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Free-running cycle counter for one bit slot or the latch gap, with terminal-count
// flags for each of the timing thresholds the transmitter compares against.
module ws2812_bit_timer
   import ws2812_pkg::*;
#(
   parameter int T0H  = WS_T0H,
   parameter int T1H  = WS_T1H,
   parameter int TBIT = WS_TBIT,
   parameter int TRES = WS_TRES
)(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc_t0h,
   output logic tc_t1h,
   output logic tc_tbit,
   output logic tc_tres
);

   localparam int CNT_W = $clog2(max2(TBIT, TRES));

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Flags mark the last cycle of each interval so the FSM moves on the following edge
   assign tc_t0h  = (cnt == CNT_W'(T0H - 1));
   assign tc_t1h  = (cnt == CNT_W'(T1H - 1));
   assign tc_tbit = (cnt == CNT_W'(TBIT - 1));
   assign tc_tres = (cnt == CNT_W'(TRES - 1));

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 single-wire NRZ transmitter: serialises a GRB frame MSB first (LED0 first),
// then holds the line low for the latch gap before pulsing done.
module ws2812_tx
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS = 5,
   parameter int T0H      = WS_T0H,
   parameter int T1H      = WS_T1H,
   parameter int TBIT     = WS_TBIT,
   parameter int TRES     = WS_TRES
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic [LED_BITS*NUM_LEDS-1:0] GRBSeq,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic                         dout
);

   localparam int FRAME_W = LED_BITS * NUM_LEDS;
   localparam int IDX_W   = $clog2(FRAME_W);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BIT_HI = 2'd1;
   localparam logic [1:0] BIT_LO = 2'd2;
   localparam logic [1:0] LATCH  = 2'd3;

   generate
      if (T1H >= TBIT || T0H == 0) begin : g_bad_timing
         $fatal(1, "ws2812_tx: illegal bit timing, need T0H > 0 and T1H < TBIT");
      end
   endgenerate

   logic [1:0]         state;
   logic [FRAME_W-1:0] sreg;
   logic [IDX_W-1:0]   idx;
   logic               cur_bit;
   logic               clr;
   logic               en;
   logic               tc_t0h;
   logic               tc_t1h;
   logic               tc_tbit;
   logic               tc_tres;

   assign cur_bit = sreg[FRAME_W-1];
   assign en      = (state != IDLE);
   assign clr     = (state == IDLE) ||
                    (state == BIT_LO && tc_tbit) ||
                    (state == LATCH && tc_tres);

   ws2812_bit_timer #(
      .T0H  (T0H),
      .T1H  (T1H),
      .TBIT (TBIT),
      .TRES (TRES)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .en      (en),
      .tc_t0h  (tc_t0h),
      .tc_t1h  (tc_t1h),
      .tc_tbit (tc_tbit),
      .tc_tres (tc_tres)
   );

   // Frame data needs no reset: it is always reloaded before it is looked at
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         sreg <= GRBSeq;
      end else if (state == BIT_LO && tc_tbit && idx != '0) begin
         sreg <= {sreg[FRAME_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         dout  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= BIT_HI;
                  idx   <= IDX_W'(FRAME_W - 1);
                  busy  <= 1'b1;
                  dout  <= 1'b1;
               end
            end
            BIT_HI: begin
               if (cur_bit ? tc_t1h : tc_t0h) begin
                  state <= BIT_LO;
                  dout  <= 1'b0;
               end
            end
            BIT_LO: begin
               if (tc_tbit) begin
                  if (idx == '0) begin
                     state <= LATCH;
                  end else begin
                     idx   <= idx - IDX_W'(1);
                     state <= BIT_HI;
                     dout  <= 1'b1;
                  end
               end
            end
            LATCH: begin
               if (tc_tres) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               dout  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_tx.sv
// Randomised bench for ws2812_tx: a cycle-time reference model of the line waveform
// plus an independent pulse-width decoder that rebuilds each frame from dout.
module tb_ws2812_tx;

   localparam int NL        = 5;
   localparam int P_T0H     = 7;
   localparam int P_T1H     = 14;
   localparam int P_TBIT    = 25;
   localparam int P_TRES    = 600;
   localparam int NBITS     = 24 * NL;
   localparam int FRAME_CYC = NBITS * P_TBIT + P_TRES;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [NBITS-1:0] grb   = '0;
   logic             busy;
   logic             done;
   logic             dout;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   ws2812_tx #(
      .NUM_LEDS (NL),
      .T0H      (P_T0H),
      .T1H      (P_T1H),
      .TBIT     (P_TBIT),
      .TRES     (P_TRES)
   ) dut (
      .clk    (clk),
      .reset  (rst_n),
      .GRBSeq (grb),
      .start  (start),
      .busy   (busy),
      .done   (done),
      .dout   (dout)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Reference model: elapsed cycles since acceptance fully determine the waveform
   logic             m_active = 1'b0;
   logic             m_done   = 1'b0;
   int               m_k      = 0;
   logic [NBITS-1:0] m_frame  = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_k      <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_active) begin
            if (m_k == FRAME_CYC - 1) begin
               m_active <= 1'b0;
               m_done   <= 1'b1;
            end else begin
               m_k <= m_k + 1;
            end
         end else if (start) begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_frame  <= grb;
         end
      end
   end

   function automatic logic [2:0] model_out();  // {busy, done, dout}
      int   b;
      int   ph;
      logic bitv;
      if (!m_active) return {1'b0, m_done, 1'b0};
      b  = m_k / P_TBIT;
      ph = m_k % P_TBIT;
      if (b >= NBITS) return 3'b100;
      bitv = m_frame[NBITS-1-b];
      return {1'b1, 1'b0, (ph < (bitv ? P_T1H : P_T0H))};
   endfunction

   // Monitor: per-cycle waveform compare and pulse-width decoding of dout
   int               hi_len   = 0;
   int               ncap     = 0;
   int               nbad     = 0;
   int               ndone    = 0;
   logic [NBITS-1:0] cap      = '0;
   logic [NBITS-1:0] last_cap = '0;

   initial forever begin
      @(negedge clk);
      check("outputs", {125'd0, busy, done, dout}, {125'd0, model_out()});
      if (!rst_n) begin
         hi_len = 0;
         ncap   = 0;
         nbad   = 0;
         cap    = '0;
      end else begin
         if (dout === 1'b1) begin
            hi_len++;
         end else if (hi_len != 0) begin
            if (hi_len == P_T1H)      cap = {cap[NBITS-2:0], 1'b1};
            else if (hi_len == P_T0H) cap = {cap[NBITS-2:0], 1'b0};
            else                      nbad++;
            ncap++;
            hi_len = 0;
         end
         if (done === 1'b1) begin
            ndone++;
            last_cap = cap;
            check("decoded", cap, m_frame);
            check("bitcount", ncap, NBITS);
            check("pulse_widths", nbad, 0);
            ncap = 0;
            nbad = 0;
            cap  = '0;
         end
      end
   end

   function automatic logic [NBITS-1:0] rand_frame();
      logic [NBITS-1:0] f;
      f = '0;
      for (int i = 0; i < NL; i++) f[24*i +: 24] = 24'($urandom);
      return f;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [NBITS-1:0] f, output int e0);
      @(negedge clk);
      grb   = f;
      start = 1'b1;
      e0    = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int e0, input string tag);
      int n;
      n = 0;
      while (done !== 1'b1 && n < FRAME_CYC + 100) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) check({tag, "_timeout"}, 0, 1);
      else               check({tag, "_latency"}, cyc - e0, FRAME_CYC);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int               e0;
      int               d0;
      logic [NBITS-1:0] fa;

      // Reset and idle behaviour
      tick(3);
      check("reset_state", {busy, done, dout}, 3'b000);
      @(posedge clk);
      #2 rst_n = 1'b1;
      tick(1000);
      check("idle_no_done", ndone, 0);
      check("idle_state", {busy, done, dout}, 3'b000);

      // All-ones frame
      send({NBITS{1'b1}}, e0);
      wait_done(e0, "ones");

      // RED on LED0, the rest off
      send({ws2812_pkg::RED, {(NL-1){ws2812_pkg::OFF}}}, e0);
      wait_done(e0, "red");

      // Random frames
      for (int i = 0; i < 3; i++) begin
         send(rand_frame(), e0);
         wait_done(e0, "rand");
      end

      // Input changes and start retriggers while a frame is in flight
      fa = rand_frame();
      send(fa, e0);
      d0 = ndone;
      tick(1000);
      for (int i = 0; i < 3; i++) begin
         grb   = rand_frame();
         start = 1'b1;
         tick(1);
         start = 1'b0;
         tick(50);
         check("busy_hold", busy, 1'b1);
      end
      wait_done(e0, "midchg");
      tick(1);
      check("midchg_frame", last_cap, fa);
      tick(300);
      check("midchg_one_done", ndone - d0, 1);

      // Asynchronous reset in the middle of a high pulse
      send(rand_frame(), e0);
      while (cyc < e0 + 2000) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_dout", dout, 1'b0);
      check("async_rst_busy", busy, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      tick(5);
      send(rand_frame(), e0);
      wait_done(e0, "post_rst");

      // start held high: back-to-back frames
      @(negedge clk);
      grb   = rand_frame();
      start = 1'b1;
      e0    = cyc + 1;
      for (int i = 0; i < 3; i++) begin
         wait_done(e0, "b2b");
         tick(1);
         check("b2b_rise", {busy, dout}, 2'b11);
         e0  = cyc;
         grb = rand_frame();
      end
      start = 1'b0;
      wait_done(e0, "b2b_last");
      tick(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
